// File: rtl/boot_pkg.sv
// boot_pkg: shared states and constants for the SPI-EEPROM-to-SRAM boot loader
package boot_pkg;
  typedef enum logic [2:0] {START, CMD, READ, WRITE, DONE} state_t;
  localparam logic [7:0] SPI_READ_CMD = 8'h03;
  localparam logic [15:0] MAP_BASE = 16'hC000;
  localparam int WORD_W = 16;
endpackage

// File: rtl/spi_shifter.sv
// spi_shifter: mode-0 SPI bit engine with CLK_DIV-derived SCLK and a 32-bit shift register
module spi_shifter
  import boot_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [31:0]       load,
  input  logic [5:0]        nbits,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] data
);
  logic [7:0] cnt;
  logic [5:0] bits;
  logic [31:0] sr;
  logic tick;
  assign tick = busy && !pause && cnt == 8'(CLK_DIV - 1);
  // done is combinational so the next phase can start on the very edge the last bit ends
  assign done = tick && sclk && bits == 6'd1;
  assign data = sr[WORD_W-1:0];
  always_ff @(posedge clk)
    if (rst) begin
      sclk <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
      bits <= '0;
      sr   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      sclk <= 1'b0;
      cnt  <= '0;
      bits <= nbits;
      sr   <= load;
      mosi <= load[31];
    end else if (busy && !pause) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
      if (tick) begin
        sclk <= !sclk;
        if (!sclk) sr <= {sr[30:0], miso};
        else begin
          bits <= bits - 6'd1;
          mosi <= done ? 1'b0 : sr[31];
          busy <= !done;
        end
      end
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams the program image from SPI EEPROM into SRAM, one 16-bit word per write
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int NUM_WORDS = 49152,
  parameter int WR_HOLD   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_bootAddr,
  output logic        o_bootWr,
  output logic        o_bootEn,
  output logic [15:0] o_bootData,
  output logic        o_isBooted,
  output logic        o_spiCsn,
  output logic        o_spiSclk,
  output logic        o_spiMosi,
  input  logic        i_spiMiso
);
  state_t state;
  logic [3:0] hold;
  logic start, done, busy, last_hold, last_word;
  logic [WORD_W-1:0] rd;
  assign last_hold = hold == 4'(WR_HOLD - 1);
  assign last_word = o_bootAddr == 16'(NUM_WORDS - 1);
  assign start = state == START || (state == CMD && done) ||
                 (state == WRITE && last_hold && !last_word && !busy);
  spi_shifter #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk(i_clk),
    .rst(i_rst),
    .start(start),
    .pause(state == WRITE),
    .load(state == START ? {SPI_READ_CMD, 24'h000000} : 32'h0),
    .nbits(state == START ? 6'd32 : 6'd16),
    .miso(i_spiMiso),
    .sclk(o_spiSclk),
    .mosi(o_spiMosi),
    .busy(busy),
    .done(done),
    .data(rd)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state      <= START;
      hold       <= '0;
      o_spiCsn   <= 1'b1;
      o_bootEn   <= 1'b0;
      o_bootWr   <= 1'b0;
      o_bootAddr <= '0;
      o_bootData <= '0;
      o_isBooted <= 1'b0;
    end else begin
      case (state)
        START: begin
          o_spiCsn <= 1'b0;
          state    <= CMD;
        end
        CMD: if (done) state <= READ;
        READ: if (done) begin
          state      <= WRITE;
          o_bootEn   <= 1'b1;
          o_bootWr   <= 1'b1;
          o_bootData <= rd;
          hold       <= '0;
        end
        WRITE: if (last_hold) begin
          o_bootEn <= 1'b0;
          o_bootWr <= 1'b0;
          if (last_word) begin
            state      <= DONE;
            o_spiCsn   <= 1'b1;
            o_isBooted <= 1'b1;
          end else begin
            o_bootAddr <= o_bootAddr + 16'd1;
            state      <= READ;
          end
        end else hold <= hold + 4'd1;
        default: ;
      endcase
    end
endmodule

// File: doc/boot_loader.md
# boot_loader

Copies the program binary from an external SPI serial EEPROM into the external SRAM after reset, one 16-bit word per write. It drives the boot-side control inputs of the memory bus mux (`boot` address/write/enable plus write data) and raises the "booted" flag that hands the bus to the processor core. It is the only bus master while the MCU is in the Booting state.

## Interface
Parameters:
- `CLK_DIV`, 1: system clocks per SCLK half-period; legal range 1..255.
- `NUM_WORDS`, 49152: number of words to copy; legal range 1..49152, so writes stay within 0x0000-0xBFFF.
- `WR_HOLD`, 2: cycles each SRAM write strobe is held; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: system clock.
- `i_rst` in 1: synchronous active-high reset.
- `o_bootAddr` out 16: word address of the SRAM write.
- `o_bootWr` out 1: write strobe to the memory mux.
- `o_bootEn` out 1: access enable to the memory mux.
- `o_bootData` out 16: write data, valid while `o_bootEn` is high.
- `o_isBooted` out 1: sticky flag, high once the copy is complete.
- `o_spiCsn` out 1: EEPROM chip select, active low.
- `o_spiSclk` out 1: SPI clock, mode 0.
- `o_spiMosi` out 1: SPI data to the EEPROM.
- `i_spiMiso` in 1: SPI data from the EEPROM.

## Operation
- Reset values:
  - `o_spiCsn`=1.
  - `o_spiSclk`=0, `o_spiMosi`=0.
  - `o_bootEn`=0, `o_bootWr`=0.
  - `o_bootAddr`=0x0000, `o_bootData`=0x0000.
  - `o_isBooted`=0.
  - State is START.
- START (1 cycle): drive `o_spiCsn` low, then go to CMD.
- CMD: shift 32 bits MSB-first: READ opcode 0x03, then 24-bit byte address 0x000000. Go to READ.
- READ: shift in 16 bits MSB-first. The first bit received is data bit 15, so the EEPROM byte at the even address is the upper byte. Go to WRITE.
- WRITE (`WR_HOLD` cycles):
  - `o_bootEn`=`o_bootWr`=1.
  - `o_bootAddr` and `o_bootData` are held stable.
  - SCLK is held low; CSn stays low and the EEPROM stream pauses.
  - On the last cycle:
    - If `o_bootAddr` == `NUM_WORDS`-1, go to DONE.
    - Otherwise increment `o_bootAddr` and go to READ.
- DONE (terminal):
  - `o_spiCsn`=1.
  - `o_isBooted`=1.
  - `o_bootEn`=`o_bootWr`=0.
  - `o_bootAddr` holds its last value.
  - Stays in DONE until reset.
- `o_bootEn` and `o_bootWr` are high only in WRITE. They are never asserted at an address ≥ 0xC000, so no mapped-register writes occur during boot.
- Address arithmetic is 16-bit with no wrap. The legal parameter range guarantees `o_bootAddr` ≤ 0xBFFF.
- `i_spiMiso` is sampled without a synchronizer; SCLK is generated internally, so MISO is synchronous to it.
- Reset asserted mid-operation (any state, including mid-bit or mid-WRITE): all outputs return to their reset values at the next edge. After release the full sequence restarts from START. CSn going high aborts the EEPROM read.

## Timing
- Bit period is 2×`CLK_DIV` cycles, SPI mode 0:
  - First `CLK_DIV` cycles: SCLK=0, MOSI updated at the start of the bit.
  - Last `CLK_DIV` cycles: SCLK=1.
  - `i_spiMiso` is captured on the clock edge where SCLK goes 0→1.
  - In READ, `o_spiMosi`=0.
- CSn setup: CSn falls one cycle before the first SCLK low phase of CMD.
- Phase durations:
  - START: 1 cycle.
  - CMD: 64×`CLK_DIV` cycles.
  - READ: 32×`CLK_DIV` cycles.
  - WRITE: `WR_HOLD` cycles.
- `o_bootData` updates on the cycle WRITE is entered. It is stable for the entire strobe.
- `o_isBooted` rises on the first cycle of DONE, i.e. 1 + 64·`CLK_DIV` + `NUM_WORDS`·(32·`CLK_DIV`+`WR_HOLD`) cycles after reset deasserts.
- SCLK ends low before CSn rises.

## Structure
- Shared package `boot_pkg`:
  - State enum (START, CMD, READ, WRITE, DONE).
  - `SPI_READ_CMD` = 8'h03.
  - `MAP_BASE` = 16'hC000.
  - Word-width constant 16.
- One sub-module, `spi_shifter`:
  - Generates SCLK from a `CLK_DIV` counter.
  - 32-bit shift register with a bit counter, loadable with the command word.
  - Start/busy/done handshake and a pause input for WRITE.
- `boot_loader` owns the FSM, the address counter, the write-hold counter and the outputs.

## Test plan
- Reset then release, `CLK_DIV`=1, `NUM_WORDS`=3, `WR_HOLD`=1, EEPROM model returns 0x1234, 0xABCD, 0x0F0F:
  - MOSI carries 0x03000000.
  - Three one-cycle writes at 0x0000/0x0001/0x0002 with the matching data.
  - `o_isBooted` rises at cycle 164 after reset deassert; CSn is high.
- `CLK_DIV`=3: SCLK high and low phases are exactly 3 cycles each; MISO is captured on each rising transition; data is unchanged vs. the model.
- `WR_HOLD`=4: `o_bootEn`/`o_bootWr` are high for exactly 4 cycles per word; addr/data are stable; SCLK stays low throughout.
- Reset pulsed during the 2nd READ: outputs return to reset values next cycle, then the full command is re-sent and the copy completes from address 0x0000.
- `NUM_WORDS`=49152: the last write is at 0xBFFF; no strobe ever occurs at or above 0xC000; `o_isBooted` stays high for 100 cycles after DONE.
